// File: rtl/lcd_stream_ctrl_if.sv
// Write-side handshake and LCD pin bundle for lcd_stream_ctrl.
// master = CPU/bench side, slave = the controller.
interface lcd_stream_ctrl_if;
  logic       wr_valid;
  logic       wr_ready;
  logic       wr_rs;
  logic [7:0] wr_data;
  logic       busy;
  logic       init_done;
  logic       lcd_en;
  logic       lcd_rw;
  logic       lcd_rs;
  logic [7:0] lcd_data;

  modport master (
    output wr_valid, wr_rs, wr_data,
    input  wr_ready, busy, init_done, lcd_en, lcd_rw, lcd_rs, lcd_data
  );

  modport slave (
    input  wr_valid, wr_rs, wr_data,
    output wr_ready, busy, init_done, lcd_en, lcd_rw, lcd_rs, lcd_data
  );
endinterface

// File: rtl/lcd_stream_ctrl.sv
// HD44780 character LCD driver: power-up wait, fixed init ROM, then drains a byte FIFO.
// Optional macro LCD_AUTOWRAP_EN adds cursor tracking with automatic line-wrap commands.
module lcd_stream_ctrl #(
  parameter int unsigned DEPTH          = 8,
  parameter int unsigned EN_CYCLES      = 50_000,
  parameter int unsigned SHORT_CYCLES   = 50_000,
  parameter int unsigned LONG_CYCLES    = 100_000,
  parameter int unsigned POWERUP_CYCLES = 1_000_000,
  parameter logic [7:0]  FUNC_SET       = 8'h38
) (
  input  logic               clk,
  input  logic               rst,
  lcd_stream_ctrl_if.slave   bus
);

  localparam int          AW         = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE    = {{AW{1'b0}}, 1'b1};
  localparam logic [31:0] EN_LAST    = 32'(EN_CYCLES - 1);
  localparam logic [31:0] SHORT_LAST = 32'(SHORT_CYCLES - 1);
  localparam logic [31:0] LONG_LAST  = 32'(LONG_CYCLES - 1);
  localparam logic [31:0] PWR_LAST   = 32'(POWERUP_CYCLES - 1);

  typedef enum logic [2:0] {PWR, INIT, IDLE, SETUP, PULSE, HOLD} state_e;

  state_e      state_q;
  logic [31:0] cnt_q;
  logic [2:0]  rom_idx_q;
  logic        init_done_q;
  logic        lcd_en_q;
  logic        lcd_rs_q;
  logic [7:0]  lcd_data_q;

  logic [8:0]  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        empty, full, push, pop, wrap_hold, long_hold;
  logic [8:0]  head;
  logic [7:0]  rom_byte;
  logic [31:0] hold_last;

`ifdef LCD_AUTOWRAP_EN
  logic       line_q;
  logic [3:0] col_q;
  logic       wrap_pend_q;
  assign wrap_hold = wrap_pend_q;
`else
  assign wrap_hold = 1'b0;
`endif

  // Extra MSB on the pointers distinguishes full from empty when the indices match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push  = bus.wr_valid && !full;
  assign pop   = (state_q == IDLE) && !empty && !wrap_hold;
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  assign long_hold = !lcd_rs_q && (lcd_data_q == 8'h01 || lcd_data_q == 8'h02);
  assign hold_last = long_hold ? LONG_LAST : SHORT_LAST;

  always_comb begin
    // NOTE: default assigned first so no path through the case can infer a latch.
    rom_byte = 8'h80;
    case (rom_idx_q)
      3'd0:    rom_byte = FUNC_SET;
      3'd1:    rom_byte = 8'h0E;
      3'd2:    rom_byte = 8'h01;
      3'd3:    rom_byte = 8'h06;
      default: ;
    endcase
  end

  // NOTE: storage is not reset; flushing the FIFO only needs the pointers cleared.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {bus.wr_rs, bus.wr_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= PWR;
      cnt_q       <= '0;
      rom_idx_q   <= '0;
      init_done_q <= 1'b0;
      lcd_en_q    <= 1'b0;
      lcd_rs_q    <= 1'b0;
      lcd_data_q  <= '0;
`ifdef LCD_AUTOWRAP_EN
      line_q      <= 1'b0;
      col_q       <= '0;
      wrap_pend_q <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        PWR: begin
          if (cnt_q == PWR_LAST) begin
            cnt_q   <= '0;
            state_q <= INIT;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        INIT: begin
          lcd_rs_q   <= 1'b0;
          lcd_data_q <= rom_byte;
          state_q    <= SETUP;
        end
        IDLE: begin
`ifdef LCD_AUTOWRAP_EN
          if (wrap_pend_q) begin
            lcd_rs_q    <= 1'b0;
            lcd_data_q  <= line_q ? 8'h80 : 8'hC0;
            line_q      <= !line_q;
            col_q       <= '0;
            wrap_pend_q <= 1'b0;
            state_q     <= SETUP;
          end else
`endif
          if (!empty) begin
            lcd_rs_q   <= head[8];
            lcd_data_q <= head[7:0];
            state_q    <= SETUP;
`ifdef LCD_AUTOWRAP_EN
            // The wrap command is issued from IDLE before the next pop is allowed.
            if (head[8]) begin
              if (col_q == 4'd15) wrap_pend_q <= 1'b1;
              else                col_q       <= col_q + 4'd1;
            end else if (head[7:0] == 8'h01 || head[7:0] == 8'h02 || head[7:0] == 8'h80) begin
              line_q <= 1'b0;
              col_q  <= '0;
            end else if (head[7:0] == 8'hC0) begin
              line_q <= 1'b1;
              col_q  <= '0;
            end
`endif
          end
        end
        SETUP: begin
          lcd_en_q <= 1'b1;
          state_q  <= PULSE;
        end
        PULSE: begin
          if (cnt_q == EN_LAST) begin
            cnt_q    <= '0;
            lcd_en_q <= 1'b0;
            state_q  <= HOLD;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        HOLD: begin
          if (cnt_q == hold_last) begin
            cnt_q <= '0;
            if (init_done_q) begin
              state_q <= IDLE;
            end else if (rom_idx_q == 3'd4) begin
              init_done_q <= 1'b1;
              state_q     <= IDLE;
            end else begin
              rom_idx_q <= rom_idx_q + 3'd1;
              state_q   <= INIT;
            end
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        default: state_q <= PWR;
      endcase
    end
  end

  assign bus.wr_ready  = !full;
  assign bus.busy      = (state_q != IDLE) || !empty || wrap_hold;
  assign bus.init_done = init_done_q;
  assign bus.lcd_en    = lcd_en_q;
  assign bus.lcd_rw    = 1'b0;
  assign bus.lcd_rs    = lcd_rs_q;
  assign bus.lcd_data  = lcd_data_q;

endmodule

// File: tb/tb_lcd_stream_ctrl.sv
// Randomized self-checking bench for lcd_stream_ctrl; expected byte stream and timing come
// from a queue-based model of the transfer rules (cursor wrap modelled when LCD_AUTOWRAP_EN set).
module tb_lcd_stream_ctrl;
  localparam int DEPTH  = 8;
  localparam int EN     = 2;
  localparam int SHORT  = 3;
  localparam int LONG   = 6;
  localparam int PWRUP  = 4;
  localparam int BUDGET = 2000;

  logic clk = 1'b0;
  logic rst;

  lcd_stream_ctrl_if bus();

  lcd_stream_ctrl #(
    .DEPTH(DEPTH), .EN_CYCLES(EN), .SHORT_CYCLES(SHORT), .LONG_CYCLES(LONG),
    .POWERUP_CYCLES(PWRUP), .FUNC_SET(8'h38)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         rise;
    int         fall;
  } xfer_t;

  xfer_t      obs_q[$];
  logic [8:0] exp_q[$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int busy_fall = -1;
  int idone_rise = -1;
  logic en_prev = 1'b0, busy_prev = 1'b1, idone_prev = 1'b0;
`ifdef LCD_AUTOWRAP_EN
  bit m_line = 1'b0;
  int m_col = 0;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: records every lcd_en pulse with the edge numbers of its rise and fall.
  always @(negedge clk) begin
    if (rst) begin
      en_prev = 1'b0; busy_prev = 1'b1; idone_prev = 1'b0;
    end else begin
      if (bus.lcd_en && !en_prev)
        obs_q.push_back('{rs: bus.lcd_rs, data: bus.lcd_data, rise: cyc, fall: -1});
      if (!bus.lcd_en && en_prev && obs_q.size() > 0)
        obs_q[obs_q.size()-1].fall = cyc;
      if (!bus.busy && busy_prev) busy_fall = cyc;
      if (bus.init_done && !idone_prev) idone_rise = cyc;
      en_prev = bus.lcd_en; busy_prev = bus.busy; idone_prev = bus.init_done;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int hold_of(input logic [8:0] b);
    return (!b[8] && (b[7:0] == 8'h01 || b[7:0] == 8'h02)) ? LONG : SHORT;
  endfunction

  task automatic model_push(input logic [8:0] b);
    exp_q.push_back(b);
`ifdef LCD_AUTOWRAP_EN
    if (b[8]) begin
      if (m_col == 15) begin
        exp_q.push_back({1'b0, m_line ? 8'h80 : 8'hC0});
        m_line = !m_line;
        m_col  = 0;
      end else begin
        m_col++;
      end
    end else if (b[7:0] == 8'h01 || b[7:0] == 8'h02 || b[7:0] == 8'h80) begin
      m_line = 1'b0; m_col = 0;
    end else if (b[7:0] == 8'hC0) begin
      m_line = 1'b1; m_col = 0;
    end
`endif
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_q.push_back(9'h038); exp_q.push_back(9'h00E); exp_q.push_back(9'h001);
    exp_q.push_back(9'h006); exp_q.push_back(9'h080);
`ifdef LCD_AUTOWRAP_EN
    m_line = 1'b0; m_col = 0;
`endif
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge, acc = that edge.
  task automatic push(input logic [8:0] b, output int acc);
    bus.wr_valid = 1'b1; bus.wr_rs = b[8]; bus.wr_data = b[7:0];
    acc = -1;
    for (int n = 0; n < BUDGET; n++) begin
      if (bus.wr_ready) begin
        @(negedge clk);
        acc = cyc;
        break;
      end
      @(negedge clk);
    end
    bus.wr_valid = 1'b0;
    check("push_accepted", 32'(acc >= 0), 1);
    if (acc >= 0) model_push(b);
  endtask

  task automatic wait_xfers(input int n);
    int t = 0;
    while ((obs_q.size() < n || obs_q[n-1].fall < 0) && t < BUDGET) begin
      @(negedge clk); #1; t++;
    end
    check("xfers_seen", 32'(obs_q.size() >= n && t < BUDGET), 1);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (bus.busy && t < BUDGET) begin
      @(negedge clk); #1; t++;
    end
    check("idle_reached", 32'(!bus.busy), 1);
  endtask

  // Back-to-back run: each rise follows the previous by EN + hold + 2 cycles.
  task automatic check_run(input int first, input int n, input int rise0, input string tag,
                           output int fin);
    int exp_rise = rise0;
    logic [8:0] e;
    for (int i = first; i < first + n; i++) begin
      if (exp_q.size() == 0 || i >= obs_q.size()) begin
        check($sformatf("%s_missing%0d", tag, i), 0, 1);
        break;
      end
      e = exp_q.pop_front();
      check($sformatf("%s_byte%0d", tag, i), {obs_q[i].rs, obs_q[i].data}, e);
      check($sformatf("%s_rise%0d", tag, i), obs_q[i].rise, exp_rise);
      check($sformatf("%s_width%0d", tag, i), obs_q[i].fall - obs_q[i].rise, EN);
      exp_rise += EN + hold_of(e) + 2;
    end
    fin = exp_rise - 2;
  endtask

  task automatic send_one(input logic [8:0] b, input string tag);
    int k, n, fall;
    logic [8:0] e;
    n = obs_q.size();
    push(b, k);
    @(negedge clk); #1;
    check({tag, "_bus_rs"}, bus.lcd_rs, b[8]);
    check({tag, "_bus_data"}, bus.lcd_data, b[7:0]);
    check({tag, "_en_setup"}, bus.lcd_en, 0);
    wait_idle();
    check({tag, "_count"}, obs_q.size(), n + 1);
    if (obs_q.size() == n + 1 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      fall = obs_q[n].fall;
      check({tag, "_byte"}, {obs_q[n].rs, obs_q[n].data}, e);
      check({tag, "_rise"}, obs_q[n].rise, k + 2);
      check({tag, "_width"}, fall - obs_q[n].rise, EN);
      check({tag, "_hold"}, busy_fall - fall, hold_of(e));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc, k, base, fin, idone_exp, idx0, cnt, t;
    logic [8:0] b;
    bus.wr_valid = 1'b0; bus.wr_rs = 1'b0; bus.wr_data = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_lcd_en", bus.lcd_en, 0);
    check("rst_lcd_rs", bus.lcd_rs, 0);
    check("rst_lcd_rw", bus.lcd_rw, 0);
    check("rst_lcd_data", bus.lcd_data, 0);
    check("rst_init_done", bus.init_done, 0);
    check("rst_wr_ready", bus.wr_ready, 1);
    check("rst_busy", bus.busy, 1);

    // Init sequence with 9 random bytes pushed while it runs.
    rst = 1'b0;
    base = cyc;
    model_reset();
    for (int i = 0; i < 9; i++) begin
      b = {1'($urandom_range(0, 1)), 8'($urandom)};
      push(b, acc);
      if (i == 7) check("full_after_8", bus.wr_ready, 0);
    end
    idone_exp = base + PWRUP + 5 * (EN + 2) + 4 * SHORT + LONG;
    check("ninth_accept_edge", acc, idone_exp + 2);
    wait_xfers(14);
    check_run(0, 14, base + PWRUP + 2, "init", fin);
    wait_idle();
    check("init_done_edge", idone_rise, idone_exp);
    check("init_done_level", bus.init_done, 1);
    check("run1_busy_fall", busy_fall, fin);

    // Single transfers: long hold, character latency, short hold.
    send_one({1'b0, 8'h02}, "cmd02");
    send_one({1'b1, 8'h41}, "char41");
    send_one({1'b0, 8'h0C}, "cmd0C");

    // Clear then 17 characters; wrap command expected only with the autowrap feature.
    idx0 = obs_q.size();
    push({1'b0, 8'h01}, k);
    for (int i = 0; i < 17; i++) push({1'b1, 8'h20 + 8'($urandom_range(0, 94))}, acc);
    wait_idle();
    cnt = exp_q.size();
    check("wrap_count", obs_q.size() - idx0, cnt);
    check_run(idx0, cnt, k + 2, "wrap", fin);
    check("wrap_busy_fall", busy_fall, fin);

    // Reset in the middle of a pulse.
    push({1'b1, 8'h55}, acc);
    push({1'b1, 8'h66}, acc);
    t = 0;
    while (!bus.lcd_en && t < 100) begin
      @(negedge clk); #1; t++;
    end
    check("pre_rst_en_high", bus.lcd_en, 1);
    #1 rst = 1'b1;
    #1;
    check("abort_lcd_en", bus.lcd_en, 0);
    check("abort_init_done", bus.init_done, 0);
    check("abort_wr_ready", bus.wr_ready, 1);
    check("abort_busy", bus.busy, 1);
    check("abort_lcd_data", bus.lcd_data, 0);
    @(negedge clk);
    rst = 1'b0;
    base = cyc;
    obs_q.delete();
    model_reset();
    wait_xfers(5);
    check_run(0, 5, base + PWRUP + 2, "reinit", fin);
    wait_idle();
    check("reinit_done_edge", idone_rise, fin);
    check("reinit_fifo_flushed", busy_fall, fin);
    repeat (20) @(negedge clk);
    check("reinit_no_extra", obs_q.size(), 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
